reaction_timer_multi: RTL and testbench
=======================================

# reaction_timer_multi

Parametrised multi-round reaction timer: arms after a pseudo-random delay, lights `led`, measures the press latency in milliseconds, detects early presses and timeouts, and accumulates best and average over a session of `NUM_ROUNDS` rounds. Outputs are binary; BCD conversion and seven-segment multiplexing stay in the existing downstream decoder path. The block replaces the single-shot timer core in the top level.

## Interface
- `TIC_DIV`, 100000: clk cycles per 1 ms tick (>= 2).
- `MAX_MS`, 999: reaction-count ceiling; reaching it is a timeout.
- `NUM_ROUNDS`, 4: rounds per session; power of two, 2..16.
- `DELAY_MIN_MS`, 1000: minimum random pre-arm delay.
- `RAND_BITS`, 11: random delay span, 0..2^RAND_BITS-1 ms added to minimum.
- Derived: `MS_W = $clog2(MAX_MS+1)`, `RND_W = $clog2(NUM_ROUNDS)`.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: debounced, synchronised level; rising edge used.
- `stop` in 1: debounced, synchronised level; rising edge used.
- `led` out 1: high only in ARMED.
- `state` out 3: IDLE=0, WAIT=1, ARMED=2, DONE=3, CHEAT=4, TIMEOUT=5, SUMMARY=6.
- `round_idx` out RND_W: current round, 0-based.
- `result_ms` out MS_W: last round result.
- `result_valid` out 1: one-cycle pulse when `result_ms` updates.
- `best_ms` out MS_W: minimum result this session.
- `avg_ms` out MS_W: session average, valid in SUMMARY.
- `avg_valid` out 1: one-cycle pulse on SUMMARY entry.
- `cheat` out 1: high in CHEAT.

## Operation
- Edge detect: `start_e = start & ~start_q`, likewise `stop_e`; `_q` registers reset to 0.
- Prescaler counts 0..TIC_DIV-1, `tic` when at TIC_DIV-1; forced to 0 on every entry to WAIT and ARMED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 on reset, steps every clk, never zero.
- IDLE: `start_e` -> WAIT, `round_idx`=0, stats cleared. `stop_e` ignored.
- WAIT: on entry delay counter loaded with `DELAY_MIN_MS + lfsr[RAND_BITS-1:0]`; decrements per `tic`; reaching 0 on a `tic` -> ARMED. `stop_e` -> CHEAT (priority over arm). `start_e` ignored.
- ARMED: `ms_cnt` cleared on entry, +1 per `tic`. `stop_e` -> DONE, `result_ms = ms_cnt` (pre-increment value when `tic` coincides). `tic` with `ms_cnt == MAX_MS-1` and no `stop_e` -> TIMEOUT, `result_ms = MAX_MS`.
- DONE/TIMEOUT: result added to `sum` (width MS_W+RND_W, no overflow possible), `best_ms = min(best_ms, result_ms)`. If this was round NUM_ROUNDS-1 -> SUMMARY next cycle; else `start_e` -> WAIT, `round_idx`+1.
- CHEAT: round not consumed, no stats update, `result_valid` not pulsed. `start_e` -> WAIT, same `round_idx`.
- SUMMARY: `avg_ms = sum >> RND_W` (truncating). `start_e` -> WAIT, new session: `round_idx`=0, `sum`=0, `best_ms`=MAX_MS.
- `stop_e` in IDLE/DONE/TIMEOUT/CHEAT/SUMMARY ignored.

## Timing
- Reset values: `state`=IDLE, `led`=0, `round_idx`=0, `result_ms`=0, `best_ms`=MAX_MS, `avg_ms`=0, `result_valid`=0, `avg_valid`=0, `cheat`=0, `sum`=0.
- `rst` mid-operation: all of the above next edge, regardless of state; LFSR reseeds.
- Edge at cycle t (input high at t, low at t-1) -> state change visible at t+1.
- `led` rises the cycle after the final WAIT `tic`; falls with the state change out of ARMED.
- `result_valid` high exactly at t+1 for DONE/TIMEOUT; `best_ms` updated same cycle.
- `avg_valid`/`avg_ms` valid the cycle after the last result, i.e. result_valid+1.
- Held `start`/`stop` levels produce one edge only.

## Test plan
- TIC_DIV=4, MAX_MS=15, NUM_ROUNDS=4, DELAY_MIN_MS=2, RAND_BITS=2 for all scenarios.
- Reset then `start` -> WAIT; delay 2..5 ms, `led` rises; `stop` after 7 tics -> `result_ms`=7, `result_valid` one cycle, `best_ms`=7.
- `stop` during WAIT -> CHEAT, `cheat`=1, `round_idx` unchanged, no `result_valid`; `start` -> WAIT same round.
- No `stop` in ARMED -> TIMEOUT after 15 ms, `result_ms`=15, counted in sum.
- Four rounds 4,8,3,15 -> SUMMARY, `avg_ms`=7, `best_ms`=3, `avg_valid` one cycle; `start` resets stats.
- `rst` asserted mid-ARMED -> next cycle IDLE, `led`=0, all outputs at reset values; `stop` coincident with `tic` captures pre-increment count.

Source files
------------

// File: rtl/reaction_timer_multi.sv
// Multi-round reaction timer. Each round waits a pseudo-random delay, then lights led
// and times the stop press in ms. Best and average results are kept per session.
module reaction_timer_multi #(
  parameter int unsigned TIC_DIV      = 100000,
  parameter int unsigned MAX_MS       = 999,
  parameter int unsigned NUM_ROUNDS   = 4,
  parameter int unsigned DELAY_MIN_MS = 1000,
  parameter int unsigned RAND_BITS    = 11,
  localparam int unsigned MS_W        = $clog2(MAX_MS + 1),
  localparam int unsigned RND_W       = $clog2(NUM_ROUNDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  output logic             led,
  output logic [2:0]       state,
  output logic [RND_W-1:0] round_idx,
  output logic [MS_W-1:0]  result_ms,
  output logic             result_valid,
  output logic [MS_W-1:0]  best_ms,
  output logic [MS_W-1:0]  avg_ms,
  output logic             avg_valid,
  output logic             cheat
);

  localparam int unsigned PRE_W = $clog2(TIC_DIV);
  localparam int unsigned DLY_W = $clog2(DELAY_MIN_MS + (1 << RAND_BITS));
  localparam int unsigned SUM_W = MS_W + RND_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_ARMED   = 3'd2,
    S_DONE    = 3'd3,
    S_CHEAT   = 3'd4,
    S_TIMEOUT = 3'd5,
    S_SUMMARY = 3'd6
  } state_t;

  state_t           cur;
  state_t           nxt;
  logic             start_q;
  logic             stop_q;
  logic             start_e;
  logic             stop_e;
  logic [PRE_W-1:0] presc;
  logic             tic;
  logic [15:0]      lfsr;
  logic [DLY_W-1:0] delay;
  logic [MS_W-1:0]  ms_cnt;
  logic [SUM_W-1:0] sum;
  logic             last_round;
  logic             enter_wait;
  logic             enter_armed;
  logic             capture;
  logic [MS_W-1:0]  capture_val;
  logic             new_session;
  logic             advance;
  logic             enter_summary;

  assign start_e    = start & ~start_q;
  assign stop_e     = stop & ~stop_q;
  assign tic        = (presc == PRE_W'(TIC_DIV - 1));
  assign last_round = (round_idx == RND_W'(NUM_ROUNDS - 1));
  assign enter_wait  = (nxt == S_WAIT) && (cur != S_WAIT);
  assign enter_armed = (nxt == S_ARMED) && (cur != S_ARMED);

  assign state = cur;
  assign led   = (cur == S_ARMED);
  assign cheat = (cur == S_CHEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      cur     <= S_IDLE;
      lfsr    <= 16'hACE1;
    end else begin
      start_q <= start;
      stop_q  <= stop;
      cur     <= nxt;
      // Fibonacci taps 16,14,13,11; a nonzero seed never reaches the all-zero lock state
      lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  always_comb begin
    nxt           = cur;
    capture       = 1'b0;
    capture_val   = '0;
    new_session   = 1'b0;
    advance       = 1'b0;
    enter_summary = 1'b0;
    case (cur)
      S_IDLE: begin
        if (start_e) begin
          nxt         = S_WAIT;
          new_session = 1'b1;
        end
      end
      S_WAIT: begin
        if (stop_e) begin
          nxt = S_CHEAT;
        end else if (tic && (delay <= DLY_W'(1))) begin
          nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (stop_e) begin
          nxt         = S_DONE;
          capture     = 1'b1;
          capture_val = ms_cnt;
        end else if (tic && (ms_cnt == MS_W'(MAX_MS - 1))) begin
          nxt         = S_TIMEOUT;
          capture     = 1'b1;
          capture_val = MS_W'(MAX_MS);
        end
      end
      S_DONE, S_TIMEOUT: begin
        if (last_round) begin
          nxt           = S_SUMMARY;
          enter_summary = 1'b1;
        end else if (start_e) begin
          nxt     = S_WAIT;
          advance = 1'b1;
        end
      end
      S_CHEAT: begin
        if (start_e) begin
          nxt = S_WAIT;
        end
      end
      S_SUMMARY: begin
        if (start_e) begin
          nxt         = S_WAIT;
          new_session = 1'b1;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Prescaler restarts on WAIT/ARMED entry so every ms interval there is a full one
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (enter_wait || enter_armed || tic) begin
      presc <= '0;
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      delay <= '0;
    end else if (enter_wait) begin
      delay <= DLY_W'(DELAY_MIN_MS) + DLY_W'(lfsr[RAND_BITS-1:0]);
    end else if ((cur == S_WAIT) && tic && (delay != '0)) begin
      delay <= delay - DLY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ms_cnt <= '0;
    end else if (enter_armed) begin
      ms_cnt <= '0;
    end else if ((cur == S_ARMED) && tic) begin
      ms_cnt <= ms_cnt + MS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round_idx    <= '0;
      result_ms    <= '0;
      result_valid <= 1'b0;
      best_ms      <= MS_W'(MAX_MS);
      avg_ms       <= '0;
      avg_valid    <= 1'b0;
      sum          <= '0;
    end else begin
      result_valid <= capture;
      avg_valid    <= enter_summary;
      if (new_session) begin
        round_idx <= '0;
        sum       <= '0;
        best_ms   <= MS_W'(MAX_MS);
      end
      if (advance) begin
        round_idx <= round_idx + RND_W'(1);
      end
      if (capture) begin
        result_ms <= capture_val;
        sum       <= sum + SUM_W'(capture_val);
        if (capture_val < best_ms) begin
          best_ms <= capture_val;
        end
      end
      if (enter_summary) begin
        avg_ms <= sum[SUM_W-1:RND_W];
      end
    end
  end

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Scoreboard bench for reaction_timer_multi: expected results are queued as stop
// presses (or timeouts) are set up and compared when result_valid / avg_valid fire.
module tb_reaction_timer_multi;

  localparam int unsigned TIC_DIV      = 4;
  localparam int unsigned MAX_MS       = 15;
  localparam int unsigned NUM_ROUNDS   = 4;
  localparam int unsigned DELAY_MIN_MS = 2;
  localparam int unsigned RAND_BITS    = 2;
  localparam int unsigned MS_W         = 4;
  localparam int unsigned RND_W        = 2;
  localparam int unsigned DELAY_MAX_MS = DELAY_MIN_MS + (1 << RAND_BITS) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             led;
  logic [2:0]       state;
  logic [RND_W-1:0] round_idx;
  logic [MS_W-1:0]  result_ms;
  logic             result_valid;
  logic [MS_W-1:0]  best_ms;
  logic [MS_W-1:0]  avg_ms;
  logic             avg_valid;
  logic             cheat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int res;
    int best;
  } res_t;

  res_t exp_res[$];
  int   exp_avg[$];
  int   best_m;
  int   sum_m;
  int   round_m;

  always #5 clk = ~clk;

  reaction_timer_multi #(
    .TIC_DIV     (TIC_DIV),
    .MAX_MS      (MAX_MS),
    .NUM_ROUNDS  (NUM_ROUNDS),
    .DELAY_MIN_MS(DELAY_MIN_MS),
    .RAND_BITS   (RAND_BITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .led         (led),
    .state       (state),
    .round_idx   (round_idx),
    .result_ms   (result_ms),
    .result_valid(result_valid),
    .best_ms     (best_ms),
    .avg_ms      (avg_ms),
    .avg_valid   (avg_valid),
    .cheat       (cheat)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic rv_prev = 1'b0;
  logic av_prev = 1'b0;

  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      check_eq("result_valid_width", rv_prev, 0);
      if (exp_res.size() == 0) begin
        check_eq("unexpected_result", result_valid, 0);
      end else begin
        res_t e;
        e = exp_res.pop_front();
        check_eq("result_ms", result_ms, e.res);
        check_eq("best_ms", best_ms, e.best);
      end
    end
    if (avg_valid === 1'b1) begin
      check_eq("avg_valid_width", av_prev, 0);
      check_eq("summary_state", state, 6);
      if (exp_avg.size() == 0) begin
        check_eq("unexpected_avg", avg_valid, 0);
      end else begin
        check_eq("avg_ms", avg_ms, exp_avg.pop_front());
      end
    end
    rv_prev = result_valid;
    av_prev = avg_valid;
  end

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_state"}, state, 0);
    check_eq({tag, "_led"}, led, 0);
    check_eq({tag, "_round"}, round_idx, 0);
    check_eq({tag, "_result"}, result_ms, 0);
    check_eq({tag, "_best"}, best_ms, MAX_MS);
    check_eq({tag, "_avg"}, avg_ms, 0);
    check_eq({tag, "_rv"}, result_valid, 0);
    check_eq({tag, "_av"}, avg_valid, 0);
    check_eq({tag, "_cheat"}, cheat, 0);
  endtask

  // All stimulus tasks start and end at #1 after a rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic start_round(input bit new_sess);
    if (new_sess) begin
      best_m  = MAX_MS;
      sum_m   = 0;
      round_m = 0;
    end
    pulse_start();
    check_eq("wait_entry", state, 1);
    check_eq("wait_round", round_idx, round_m);
    check_eq("wait_led", led, 0);
    if (new_sess) check_eq("session_best", best_ms, MAX_MS);
  endtask

  task automatic wait_led(output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < int'(TIC_DIV * (DELAY_MAX_MS + 1))) begin
      @(posedge clk); #1;
      n++;
      if (led === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("led_rise", led, 1);
    if (ok) begin
      check_eq("arm_delay_ok", (n % TIC_DIV == 0) && (n / TIC_DIV >= DELAY_MIN_MS) &&
               (n / TIC_DIV <= DELAY_MAX_MS), 1);
      check_eq("armed_state", state, 2);
    end
  endtask

  task automatic expect_result(input int res);
    res_t e;
    if (res < best_m) best_m = res;
    sum_m += res;
    e.res  = res;
    e.best = best_m;
    exp_res.push_back(e);
    if (round_m == NUM_ROUNDS - 1) exp_avg.push_back(sum_m >> RND_W);
    round_m++;
  endtask

  // kind 0: stop k ms after arm; kind 1: stop lands on the k-th tic; kind 2: timeout
  task automatic play_round(input bit new_sess, input int kind, input int k);
    bit ok;
    int c;
    start_round(new_sess);
    wait_led(ok);
    if (!ok) return;
    if (kind == 2) begin
      expect_result(MAX_MS);
      c = 0;
      while (c < int'(TIC_DIV * MAX_MS + 8)) begin
        @(posedge clk); #1;
        c++;
        if (state === 3'd5) break;
      end
      check_eq("timeout_cycles", c, TIC_DIV * MAX_MS);
      check_eq("timeout_led", led, 0);
    end else begin
      expect_result(kind == 0 ? k : k - 1);
      repeat (kind == 0 ? TIC_DIV * k : TIC_DIV * k - 1) @(posedge clk);
      #1;
      stop = 1'b1;
      @(posedge clk); #1;
      check_eq("done_state", state, 3);
      check_eq("done_led", led, 0);
    end
    repeat (3) @(posedge clk);
    #1;
    stop = 1'b0;
    if (round_m == NUM_ROUNDS) begin
      check_eq("summary_hold", state, 6);
    end else begin
      check_eq("result_hold", state, kind == 2 ? 5 : 3);
      check_eq("result_round", round_idx, round_m - 1);
    end
  endtask

  task automatic play_cheat();
    start_round(1'b0);
    @(posedge clk); #1;
    pulse_start();
    check_eq("start_ignored_wait", state, 1);
    stop = 1'b1;
    @(posedge clk); #1;
    check_eq("cheat_state", state, 4);
    check_eq("cheat_flag", cheat, 1);
    check_eq("cheat_round", round_idx, round_m);
    check_eq("cheat_led", led, 0);
    repeat (3) @(posedge clk);
    #1;
    stop = 1'b0;
    check_eq("cheat_hold", state, 4);
  endtask

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    check_eq("stop_ignored_idle", state, 0);
    stop = 1'b0;

    // Session 1: 7, cheat, 3 (stop on a tic), timeout 15, 8 -> avg 8, best 3
    play_round(1'b1, 0, 7);
    play_cheat();
    play_round(1'b0, 1, 4);
    play_round(1'b0, 2, 0);
    play_round(1'b0, 0, 8);

    // Session 2 from SUMMARY: 4, 8, 3, 15 -> avg 7, best 3
    play_round(1'b1, 0, 4);
    play_round(1'b0, 0, 8);
    play_round(1'b0, 0, 3);
    play_round(1'b0, 2, 0);

    // Session 3: reset while ARMED
    start_round(1'b1);
    wait_led(ok);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values("mid_reset");
    rst = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    check_eq("results_pending", exp_res.size(), 0);
    check_eq("avg_pending", exp_avg.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
